// File: rtl/liteic_slave_node_write_ooo_pkg.sv
// Shared constants, FSM state type and width helper for the liteic write slave node.
package liteic_slave_node_write_ooo_pkg;

  localparam int LITEIC_NUM_MST         = 4;
  localparam int LITEIC_AWADDR_W        = 32;
  localparam int LITEIC_WDATA_W         = 36;
  localparam int LITEIC_BRESP_W         = 2;
  localparam int LITEIC_MAX_OUTSTANDING = 4;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_XFER = 1'b1
  } wr_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/liteic_slave_node_write_ooo_if.sv
// Bundles the per-master request side and the single slave port of the write node.
interface liteic_slave_node_write_ooo_if
  import liteic_slave_node_write_ooo_pkg::*;
#(
  parameter int NUM_MST  = LITEIC_NUM_MST,
  parameter int AWADDR_W = LITEIC_AWADDR_W,
  parameter int WDATA_W  = LITEIC_WDATA_W,
  parameter int BRESP_W  = LITEIC_BRESP_W
);

  logic [NUM_MST*AWADDR_W-1:0] mst_aw_data_i;
  logic [NUM_MST-1:0]          mst_aw_valid_i;
  logic [NUM_MST-1:0]          mst_aw_ready_o;
  logic [NUM_MST*WDATA_W-1:0]  mst_w_data_i;
  logic [NUM_MST-1:0]          mst_w_valid_i;
  logic [NUM_MST-1:0]          mst_w_ready_o;
  logic [NUM_MST-1:0]          mst_b_valid_o;
  logic [NUM_MST-1:0]          mst_b_ready_i;
  logic [BRESP_W-1:0]          mst_b_resp_o;

  logic [AWADDR_W-1:0]         slv_aw_addr_o;
  logic                        slv_aw_valid_o;
  logic                        slv_aw_ready_i;
  logic [WDATA_W-1:0]          slv_w_data_o;
  logic                        slv_w_valid_o;
  logic                        slv_w_ready_i;
  logic [BRESP_W-1:0]          slv_b_resp_i;
  logic                        slv_b_valid_i;
  logic                        slv_b_ready_o;

  modport slave (
    input  mst_aw_data_i, mst_aw_valid_i, mst_w_data_i, mst_w_valid_i, mst_b_ready_i,
    output mst_aw_ready_o, mst_w_ready_o, mst_b_valid_o, mst_b_resp_o,
    output slv_aw_addr_o, slv_aw_valid_o, slv_w_data_o, slv_w_valid_o, slv_b_ready_o,
    input  slv_aw_ready_i, slv_w_ready_i, slv_b_resp_i, slv_b_valid_i
  );

  modport master (
    output mst_aw_data_i, mst_aw_valid_i, mst_w_data_i, mst_w_valid_i, mst_b_ready_i,
    input  mst_aw_ready_o, mst_w_ready_o, mst_b_valid_o, mst_b_resp_o,
    input  slv_aw_addr_o, slv_aw_valid_o, slv_w_data_o, slv_w_valid_o, slv_b_ready_o,
    output slv_aw_ready_i, slv_w_ready_i, slv_b_resp_i, slv_b_valid_i
  );

endinterface

// File: rtl/liteic_slave_node_write_ooo_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward (wrapping); an advance pulse
// moves the pointer just past the index that was served.
module liteic_slave_node_write_ooo_rr_arbiter
  import liteic_slave_node_write_ooo_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  input  logic [IW-1:0] adv_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N) cand = cand - N;
      if (!gnt_valid_o && req_i[IW'(cand)]) begin
        gnt_valid_o         = 1'b1;
        gnt_idx_o           = IW'(cand);
        gnt_o[IW'(cand)]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (adv_idx_i == IW'(N - 1)) ? '0 : adv_idx_i + IW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/liteic_slave_node_write_ooo.sv
// Write slave node: round-robin merges master AW/W onto one slave port and returns
// B responses in AW issue order through an ID FIFO.
module liteic_slave_node_write_ooo
  import liteic_slave_node_write_ooo_pkg::*;
#(
  parameter int NUM_MST         = LITEIC_NUM_MST,
  parameter int AWADDR_W        = LITEIC_AWADDR_W,
  parameter int WDATA_W         = LITEIC_WDATA_W,
  parameter int BRESP_W         = LITEIC_BRESP_W,
  parameter int MAX_OUTSTANDING = LITEIC_MAX_OUTSTANDING
) (
  input logic                          clk_i,
  input logic                          rst_i,
  liteic_slave_node_write_ooo_if.slave bus
);

  localparam int IW = idx_width(NUM_MST);
  localparam int PW = idx_width(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  wr_state_e          state_q, state_d;
  logic [IW-1:0]      g_q, g_d;
  logic [NUM_MST-1:0] gnt_oh_q, gnt_oh_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [NUM_MST-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic               advance;

  logic [IW-1:0]      id_mem_q [MAX_OUTSTANDING];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic               fifo_full, fifo_empty;
  logic [IW-1:0]      head;

  logic               in_xfer, aw_hs, w_hs, push, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  liteic_slave_node_write_ooo_rr_arbiter #(.N(NUM_MST)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (bus.mst_aw_valid_i),
    .advance_i   (advance),
    .adv_idx_i   (g_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_mem_q[rd_ptr_q];

  assign in_xfer = (state_q == WR_XFER);
  assign aw_hs   = bus.slv_aw_valid_o & bus.slv_aw_ready_i;
  assign w_hs    = bus.slv_w_valid_o & bus.slv_w_ready_i;
  assign push    = aw_hs;
  assign pop     = bus.slv_b_valid_i & bus.slv_b_ready_o;

  assign bus.slv_aw_addr_o  = bus.mst_aw_data_i[g_q*AWADDR_W +: AWADDR_W];
  assign bus.slv_w_data_o   = bus.mst_w_data_i[g_q*WDATA_W +: WDATA_W];
  assign bus.slv_aw_valid_o = in_xfer & bus.mst_aw_valid_i[g_q] & ~aw_done_q;
  assign bus.slv_w_valid_o  = in_xfer & bus.mst_w_valid_i[g_q] & ~w_done_q;
  assign bus.mst_aw_ready_o = (in_xfer && bus.slv_aw_ready_i && !aw_done_q) ? gnt_oh_q : '0;
  assign bus.mst_w_ready_o  = (in_xfer && bus.slv_w_ready_i && !w_done_q) ? gnt_oh_q : '0;

  // B is steered to whoever owns the oldest outstanding AW; an empty FIFO routes nothing.
  assign bus.mst_b_valid_o = (bus.slv_b_valid_i && !fifo_empty) ? (NUM_MST'(1) << head) : '0;
  assign bus.slv_b_ready_o = bus.mst_b_ready_i[head] & ~fifo_empty;
  assign bus.mst_b_resp_o  = bus.slv_b_resp_i;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    gnt_oh_d  = gnt_oh_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    advance   = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        if (!fifo_full && arb_valid) begin
          state_d  = WR_XFER;
          g_d      = arb_idx;
          gnt_oh_d = arb_gnt;
        end
      end
      WR_XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WR_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          advance   = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= WR_IDLE;
      g_q       <= '0;
      gnt_oh_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      gnt_oh_q  <= gnt_oh_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // A grant is only issued below full, so a push can never overflow; a pop may coincide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_mem_q[i] <= '0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= g_q;
        wr_ptr_q           <= wrap_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
